// File: rtl/uart_echo_pkg.sv
// Shared types, character constants and helpers for the UART echo controller.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    SEND_LF = 2'd2
  } tx_state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Oversampling prescale for uart_rx/uart_tx: clk / (baud * 8), rounded down.
  function automatic logic [15:0] calc_prescale(input int unsigned clk_hz,
                                                input int unsigned baud);
    return 16'(clk_hz / (baud * 32'd8));
  endfunction

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max);
    return (value == max) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/uart_echo_ctrl_if.sv
// AXI-Stream byte channel between the UART blocks and the echo controller.
interface uart_echo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_echo_fifo.sv
// Synchronous echo buffer. A push while full is accepted only if a pop
// frees a slot in the same cycle; otherwise it is ignored.
module uart_echo_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array write.
  // NOTE: the data array has no reset; only pointers/count define validity,
  // so leaving it unreset keeps it a plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo controller: buffers bytes from uart_rx, replays them to uart_tx with
// optional CR -> CR LF expansion, and keeps saturating event counters.
module uart_echo_ctrl
  import uart_echo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         crlf_en,
  input  logic                         clr_stats,
  uart_echo_ctrl_if.slave              rx,
  input  logic                         rx_frame_error,
  input  logic                         rx_overrun_error,
  uart_echo_ctrl_if.master             tx,
  output logic [15:0]                  prescale,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [CNT_WIDTH-1:0]         frame_err_cnt,
  output logic [CNT_WIDTH-1:0]         overrun_cnt,
  output logic [CNT_WIDTH-1:0]         drop_cnt
);

  localparam logic [15:0] PRESCALE = calc_prescale(CLK_FREQ_HZ, BAUD);
  localparam logic [31:0] CNT_MAX  = 32'((64'd1 << CNT_WIDTH) - 64'd1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  pop;
  logic                  rx_fire;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] head_data;

  // uart_rx is never backpressured while echo is enabled.
  assign rx.tready = enable;
  assign rx_fire   = rx.tvalid && enable;
  assign drop      = rx_fire && fifo_full && !pop;
  assign prescale  = PRESCALE;
  assign tx.tdata  = tx_data_q;
  assign tx.tvalid = tx_valid_q;

  uart_echo_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_fire),
    .push_data (rx.tdata),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Tx FSM state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Tx FSM next state: pop in IDLE, hold in SEND/SEND_LF until tready.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          pop        = 1'b1;
          tx_data_d  = head_data;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx.tready) begin
          if (crlf_en && (tx_data_q == DATA_WIDTH'(CHAR_CR))) begin
            tx_data_d = DATA_WIDTH'(CHAR_LF);
            state_d   = SEND_LF;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      SEND_LF: begin
        if (tx.tready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating statistics counters; clear wins over any same-cycle event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_cnt <= '0;
      overrun_cnt   <= '0;
      drop_cnt      <= '0;
    end else if (clr_stats) begin
      frame_err_cnt <= '0;
      overrun_cnt   <= '0;
      drop_cnt      <= '0;
    end else begin
      if (rx_frame_error)
        frame_err_cnt <= CNT_WIDTH'(sat_inc(32'(frame_err_cnt), CNT_MAX));
      if (rx_overrun_error)
        overrun_cnt <= CNT_WIDTH'(sat_inc(32'(overrun_cnt), CNT_MAX));
      if (drop)
        drop_cnt <= CNT_WIDTH'(sat_inc(32'(drop_cnt), CNT_MAX));
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Directed testbench for uart_echo_ctrl. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_uart_echo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       crlf_en;
  logic       clr_stats;
  logic       frame_err;
  logic       overrun_err;
  logic [15:0] prescale;
  logic [4:0]  fifo_count;
  logic [15:0] frame_err_cnt, overrun_cnt, drop_cnt;

  // Second instance with 4-bit counters for the saturation check.
  logic        frame_err2;
  logic [15:0] prescale2;
  logic [4:0]  fifo_count2;
  logic [3:0]  frame_err_cnt2, overrun_cnt2, drop_cnt2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_echo_ctrl_if #(.DATA_WIDTH(8)) rx_bus ();
  uart_echo_ctrl_if #(.DATA_WIDTH(8)) tx_bus ();
  uart_echo_ctrl_if #(.DATA_WIDTH(8)) rx_bus2 ();
  uart_echo_ctrl_if #(.DATA_WIDTH(8)) tx_bus2 ();

  uart_echo_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .crlf_en          (crlf_en),
    .clr_stats        (clr_stats),
    .rx               (rx_bus),
    .rx_frame_error   (frame_err),
    .rx_overrun_error (overrun_err),
    .tx               (tx_bus),
    .prescale         (prescale),
    .fifo_count       (fifo_count),
    .frame_err_cnt    (frame_err_cnt),
    .overrun_cnt      (overrun_cnt),
    .drop_cnt         (drop_cnt)
  );

  uart_echo_ctrl #(.CNT_WIDTH(4)) dut_sat (
    .clk              (clk),
    .rst              (rst),
    .enable           (1'b0),
    .crlf_en          (1'b0),
    .clr_stats        (1'b0),
    .rx               (rx_bus2),
    .rx_frame_error   (frame_err2),
    .rx_overrun_error (1'b0),
    .tx               (tx_bus2),
    .prescale         (prescale2),
    .fifo_count       (fifo_count2),
    .frame_err_cnt    (frame_err_cnt2),
    .overrun_cnt      (overrun_cnt2),
    .drop_cnt         (drop_cnt2)
  );

  // Drive one rx beat; called on a falling edge, returns on the next one.
  task automatic send_rx(input logic [7:0] data);
    rx_bus.tdata  = data;
    rx_bus.tvalid = 1'b1;
    @(negedge clk);
    rx_bus.tvalid = 1'b0;
  endtask

  // Wait (bounded) for tx_tvalid; ok reports whether it arrived.
  task automatic wait_tvalid(output bit ok);
    int n = 0;
    while (tx_bus.tvalid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (tx_bus.tvalid === 1'b1);
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (tx_bus.tvalid !== 1'b0 || tx_bus.tdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_tx: tvalid=%b tdata=%h, expected 0 and 00", tx_bus.tvalid, tx_bus.tdata);
    end
    vectors++;
    if (fifo_count !== 5'd0 || frame_err_cnt !== 16'd0 || overrun_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state: count=%0d frame=%0d overrun=%0d drop=%0d, expected all 0",
               fifo_count, frame_err_cnt, overrun_cnt, drop_cnt);
    end
    vectors++;
    if (prescale !== 16'd54) begin
      miscompares++;
      $display("FAIL prescale: got %0d, expected 54", prescale);
    end
  endtask

  task automatic test_latency();
    vectors++;
    if (rx_bus.tready !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_tready: got %b, expected 1 with enable=1", rx_bus.tready);
    end
    send_rx(8'h41);
    vectors++;
    if (tx_bus.tvalid !== 1'b0 || fifo_count !== 5'd1) begin
      miscompares++;
      $display("FAIL latency_edge1: tvalid=%b count=%0d, expected 0 and 1", tx_bus.tvalid, fifo_count);
    end
    @(negedge clk);
    vectors++;
    if (tx_bus.tvalid !== 1'b1 || tx_bus.tdata !== 8'h41 || fifo_count !== 5'd0) begin
      miscompares++;
      $display("FAIL latency_edge2: tvalid=%b tdata=%h count=%0d, expected 1, 41, 0",
               tx_bus.tvalid, tx_bus.tdata, fifo_count);
    end
    @(negedge clk);
    vectors++;
    if (tx_bus.tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_done: tvalid=%b, expected 0 after handshake", tx_bus.tvalid);
    end
  endtask

  task automatic test_crlf();
    logic [7:0] exp_on [3] = '{8'h0D, 8'h0A, 8'h42};
    logic [7:0] exp_off [2] = '{8'h0D, 8'h42};
    bit ok;
    crlf_en = 1'b1;
    send_rx(8'h0D);
    send_rx(8'h42);
    for (int i = 0; i < 3; i++) begin
      wait_tvalid(ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL crlf_on[%0d]: tx_tvalid never rose, expected tdata %h", i, exp_on[i]);
      end else if (tx_bus.tdata !== exp_on[i]) begin
        miscompares++;
        $display("FAIL crlf_on[%0d]: tdata=%h, expected %h", i, tx_bus.tdata, exp_on[i]);
      end
      @(negedge clk);
    end
    crlf_en = 1'b0;
    send_rx(8'h0D);
    send_rx(8'h42);
    for (int i = 0; i < 2; i++) begin
      wait_tvalid(ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL crlf_off[%0d]: tx_tvalid never rose, expected tdata %h", i, exp_off[i]);
      end else if (tx_bus.tdata !== exp_off[i]) begin
        miscompares++;
        $display("FAIL crlf_off[%0d]: tdata=%h, expected %h", i, tx_bus.tdata, exp_off[i]);
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (tx_bus.tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL crlf_off_tail: tvalid=%b with tdata=%h, expected idle", tx_bus.tvalid, tx_bus.tdata);
    end
  endtask

  task automatic test_fill_and_coincide();
    bit ok;
    logic [7:0] exp;
    tx_bus.tready = 1'b0;
    // A primer byte parks the FSM in SEND so nothing else is popped.
    send_rx(8'hEE);
    for (int i = 0; i < 18; i++) begin
      rx_bus.tdata  = 8'(i);
      rx_bus.tvalid = 1'b1;
      @(negedge clk);
    end
    rx_bus.tvalid = 1'b0;
    vectors++;
    if (fifo_count !== 5'd16 || drop_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL fill: count=%0d drop=%0d, expected 16 and 2", fifo_count, drop_cnt);
    end
    vectors++;
    if (tx_bus.tvalid !== 1'b1 || tx_bus.tdata !== 8'hEE) begin
      miscompares++;
      $display("FAIL fill_hold: tvalid=%b tdata=%h, expected 1 and EE", tx_bus.tvalid, tx_bus.tdata);
    end
    // Complete the primer, then push exactly on the IDLE pop edge.
    tx_bus.tready = 1'b1;
    @(negedge clk);
    tx_bus.tready = 1'b0;
    rx_bus.tdata  = 8'h55;
    rx_bus.tvalid = 1'b1;
    @(negedge clk);
    rx_bus.tvalid = 1'b0;
    vectors++;
    if (fifo_count !== 5'd16 || drop_cnt !== 16'd2 || tx_bus.tvalid !== 1'b1 || tx_bus.tdata !== 8'h00) begin
      miscompares++;
      $display("FAIL coincide: count=%0d drop=%0d tvalid=%b tdata=%h, expected 16, 2, 1, 00",
               fifo_count, drop_cnt, tx_bus.tvalid, tx_bus.tdata);
    end
    tx_bus.tready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      exp = (i < 16) ? 8'(i) : 8'h55;
      wait_tvalid(ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL drain[%0d]: tx_tvalid never rose, expected tdata %h", i, exp);
      end else if (tx_bus.tdata !== exp) begin
        miscompares++;
        $display("FAIL drain[%0d]: tdata=%h, expected %h", i, tx_bus.tdata, exp);
      end
      @(negedge clk);
    end
    vectors++;
    if (fifo_count !== 5'd0 || drop_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL drain_end: count=%0d drop=%0d, expected 0 and 2", fifo_count, drop_cnt);
    end
  endtask

  task automatic test_stats();
    for (int i = 0; i < 3; i++) begin
      frame_err = 1'b1;
      if (i == 1) overrun_err = 1'b1;
      @(negedge clk);
      frame_err   = 1'b0;
      overrun_err = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (frame_err_cnt !== 16'd3 || overrun_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL stats_count: frame=%0d overrun=%0d, expected 3 and 1", frame_err_cnt, overrun_cnt);
    end
    clr_stats = 1'b1;
    frame_err = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    frame_err = 1'b0;
    vectors++;
    if (frame_err_cnt !== 16'd0 || overrun_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL stats_clear: frame=%0d overrun=%0d drop=%0d, expected all 0",
               frame_err_cnt, overrun_cnt, drop_cnt);
    end
  endtask

  task automatic test_saturate();
    frame_err2 = 1'b1;
    repeat (15) @(negedge clk);
    vectors++;
    if (frame_err_cnt2 !== 4'd15) begin
      miscompares++;
      $display("FAIL sat_reach: frame=%0d, expected 15 after 15 pulses", frame_err_cnt2);
    end
    repeat (5) @(negedge clk);
    frame_err2 = 1'b0;
    vectors++;
    if (frame_err_cnt2 !== 4'd15 || overrun_cnt2 !== 4'd0 || drop_cnt2 !== 4'd0) begin
      miscompares++;
      $display("FAIL sat_hold: frame=%0d overrun=%0d drop=%0d, expected 15, 0, 0",
               frame_err_cnt2, overrun_cnt2, drop_cnt2);
    end
    vectors++;
    if (fifo_count2 !== 5'd0 || tx_bus2.tvalid !== 1'b0 || prescale2 !== 16'd54) begin
      miscompares++;
      $display("FAIL sat_idle: count=%0d tvalid=%b prescale=%0d, expected 0, 0, 54",
               fifo_count2, tx_bus2.tvalid, prescale2);
    end
  endtask

  task automatic test_async_reset();
    tx_bus.tready = 1'b0;
    send_rx(8'h61);
    send_rx(8'h62);
    frame_err = 1'b1;
    @(negedge clk);
    frame_err = 1'b0;
    vectors++;
    if (tx_bus.tvalid !== 1'b1 || tx_bus.tdata !== 8'h61 || fifo_count !== 5'd1 || frame_err_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL areset_pre: tvalid=%b tdata=%h count=%0d frame=%0d, expected 1, 61, 1, 1",
               tx_bus.tvalid, tx_bus.tdata, fifo_count, frame_err_cnt);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (tx_bus.tvalid !== 1'b0 || tx_bus.tdata !== 8'h00 || fifo_count !== 5'd0 ||
        frame_err_cnt !== 16'd0 || frame_err_cnt2 !== 4'd0) begin
      miscompares++;
      $display("FAIL areset: tvalid=%b tdata=%h count=%0d frame=%0d frame2=%0d, expected all 0",
               tx_bus.tvalid, tx_bus.tdata, fifo_count, frame_err_cnt, frame_err_cnt2);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    enable         = 1'b0;
    crlf_en        = 1'b0;
    clr_stats      = 1'b0;
    frame_err      = 1'b0;
    overrun_err    = 1'b0;
    frame_err2     = 1'b0;
    rx_bus.tdata   = 8'h00;
    rx_bus.tvalid  = 1'b0;
    tx_bus.tready  = 1'b0;
    rx_bus2.tdata  = 8'h00;
    rx_bus2.tvalid = 1'b0;
    tx_bus2.tready = 1'b1;

    test_reset();
    @(negedge clk);
    rst           = 1'b1;
    enable        = 1'b1;
    tx_bus.tready = 1'b1;
    @(negedge clk);

    test_latency();
    test_crlf();
    test_fill_and_coincide();
    test_stats();
    test_saturate();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_echo_ctrl.md
Name: uart_echo_ctrl

Overview:
- Controller between the uart_rx AXI-Stream master and the uart_tx AXI-Stream slave in the echo top level.
- Buffers received bytes in a small FIFO and sequences transmission through a tx-side FSM.
- Optionally expands CR into CR LF.
- Counts frame, overrun and drop events, and drives the shared baud prescale to both UART instances.

Parameters:
- DATA_WIDTH, 8: byte width on both streams.
- FIFO_DEPTH, 16: echo buffer entries; power of two, at least 2.
- CLK_FREQ_HZ, 50000000: system clock frequency.
- BAUD, 115200: line rate.
- CNT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- enable  in  1  echo enable.
- crlf_en  in  1  append LF (0x0A) after each CR (0x0D).
- clr_stats  in  1  one-cycle pulse that zeroes all counters.
- rx_tdata  in  DATA_WIDTH  byte from uart_rx.
- rx_tvalid  in  1  byte valid from uart_rx.
- rx_tready  out  1  ready to uart_rx.
- rx_frame_error  in  1  uart_rx frame-error pulse.
- rx_overrun_error  in  1  uart_rx overrun pulse.
- tx_tdata  out  DATA_WIDTH  byte to uart_tx.
- tx_tvalid  out  1  byte valid to uart_tx.
- tx_tready  in  1  ready from uart_tx.
- prescale  out  16  CLK_FREQ_HZ/(BAUD*8), floor; constant, shared by both UARTs.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err_cnt  out  CNT_WIDTH  frame-error count.
- overrun_cnt  out  CNT_WIDTH  overrun count.
- drop_cnt  out  CNT_WIDTH  bytes dropped because the FIFO was full.

Behaviour:
- Reset (rst low, async): FIFO empty, fifo_count=0, FSM=IDLE, tx_tvalid=0, tx_tdata=0, all counters 0. prescale is the constant at all times.
- rx_tready = enable, combinational. Never backpressure uart_rx, so receive overruns are avoided.
- Push: an rx handshake writes the byte at that edge, unless the FIFO is full and no pop occurs in the same cycle.
  - That case drops the byte and increments drop_cnt.
  - Push and pop in the same cycle when full: the push succeeds and the count is unchanged.
  - Push and pop in the same cycle when empty: not possible, because a pop requires non-empty.
- Tx FSM, states IDLE, SEND, SEND_LF:
  - IDLE: if enable and FIFO not empty, pop the head into tx_tdata, set tx_tvalid=1, go to SEND.
  - SEND: hold tx_tdata and tx_tvalid until tx_tready.
    - On the handshake, if crlf_en=1 and the byte is 0x0D: tx_tdata=0x0A, tx_tvalid stays 1, go to SEND_LF.
    - Otherwise tx_tvalid=0 and go to IDLE.
  - SEND_LF: hold until tx_tready, then tx_tvalid=0 and go to IDLE.
  - crlf_en is sampled at the SEND handshake.
- Latency: with the FIFO empty and the FSM in IDLE, an rx handshake at edge N makes tx_tvalid=1 after edge N+1. There is one IDLE bubble cycle between consecutive transmitted bytes.
- AXI rule: once tx_tvalid=1, tx_tdata is stable and tx_tvalid does not drop until the handshake, regardless of enable.
- enable deasserted mid-operation: the current SEND/SEND_LF completes and no new pop occurs. FIFO contents are retained and resume when enable returns.
- Counters:
  - frame_err_cnt increments on each rx_frame_error cycle; overrun_cnt increments on each rx_overrun_error cycle.
  - All counters saturate at all-ones with no wrap.
  - clr_stats has priority over any same-cycle increment; the result is 0.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full is count==FIFO_DEPTH; empty is count==0.

Decomposition:
- Package uart_echo_pkg:
  - tx FSM state enum {IDLE, SEND, SEND_LF}.
  - CHAR_CR=8'h0D and CHAR_LF=8'h0A.
  - Function calc_prescale(clk_hz, baud) returning 16 bits.
  - A saturating-increment function.
- Sub-module uart_echo_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised on DATA_WIDTH and FIFO_DEPTH.

Test Plan:
- Reset then enable=1; drive rx 0x41 with tx_tready=1 -> tx_tvalid rises 2 edges after the rx handshake with tx_tdata=0x41; fifo_count returns to 0; prescale=54 for 50 MHz / 115200.
- crlf_en=1; send 0x0D, 0x42 -> tx sequence 0x0D, 0x0A, 0x42. With crlf_en=0 -> 0x0D, 0x42.
- tx_tready=0; push 18 bytes 0x00..0x11 with DEPTH=16 -> fifo_count=16, drop_cnt=2. Release tready -> 0x00..0x0F emitted in order.
- Full FIFO, and a push coincides with the IDLE pop -> push accepted, drop_cnt unchanged, count stays 16.
- Pulse rx_frame_error 3 times and rx_overrun_error once -> frame_err_cnt=3, overrun_cnt=1. clr_stats coinciding with a frame pulse -> 0. With CNT_WIDTH=4, 20 pulses -> saturates at 15.
- Async reset asserted while in SEND with tx_tvalid=1 -> tx_tvalid=0, fifo_count=0 and counters 0 immediately, without waiting for a clock edge.
